// File: rtl/fx55_dec_display_pkg.sv
// Shared types, widths, segment constants and value-formation helpers for
// the 5.5 fixed-point to "dd.dd" seven-segment display block.
package fx55_dec_display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int IN_W   = 10;
   localparam int INT_W  = 5;
   localparam int FRAC_W = 5;
   localparam int BIN_W  = 12;
   localparam int BCD_W  = 16;
   localparam int CNT_W  = 4;

   // Active-low segments, bit order gfedcba
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

   // Integer part times 100 plus fraction scaled to hundredths.
   // Worst-case scaled fraction is 31*100+16 = 3116, so 12 bits suffice,
   // and the hundredths never exceed 97, so no carry into the integer part.
   function automatic logic [BIN_W-1:0] fx_to_bin(input logic [IN_W-1:0] v,
                                                  input logic rnd);
      logic [BIN_W-1:0] frac_scaled;
      logic [BIN_W-1:0] int_scaled;
      frac_scaled = BIN_W'(v[FRAC_W-1:0]) * BIN_W'(100)
                  + (rnd ? BIN_W'(16) : BIN_W'(0));
      int_scaled  = BIN_W'(v[IN_W-1:FRAC_W]) * BIN_W'(100);
      return int_scaled + {5'b0, frac_scaled[BIN_W-1:FRAC_W]};
   endfunction

   // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int n = 0; n < BCD_W / 4; n++) begin
         if (b[n*4 +: 4] >= 4'd5)
            r[n*4 +: 4] = b[n*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   // One double-dabble step: correct, then shift {bcd, bin} left by one
   function automatic logic [BCD_W+BIN_W-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                                     input logic [BIN_W-1:0] bin);
      logic [BCD_W+BIN_W-1:0] joined;
      joined = {bcd_adjust(bcd), bin};
      return joined << 1;
   endfunction

endpackage

// File: rtl/fx55_dec_display_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment (gfedcba) decoder.
// Codes above 9 cannot occur from the converter; they decode to blank.
module seg7_decode
   import fx55_dec_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Digit lookup
   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/fx55_dec_display.sv
// Converts an unsigned 5.5 fixed-point value to "dd.dd" on four active-low
// seven-segment displays using an iterative double-dabble engine. A one-deep
// pending register holds the newest value that arrives while busy.
module fx55_dec_display
   import fx55_dec_display_pkg::*;
#(
   parameter bit FRAC_ROUND    = 1'b1,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic            CLOCK_50,
   input  logic            RESET_N,
   input  logic [IN_W-1:0] in_data,
   input  logic            in_valid,
   output logic            busy,
   output logic            done,
   output logic [6:0]      HEX3,
   output logic [6:0]      HEX2,
   output logic [6:0]      HEX1,
   output logic [6:0]      HEX0
);

   state_t                 state_reg;
   logic [BIN_W-1:0]       bin_reg;
   logic [BCD_W-1:0]       bcd_reg;
   logic [CNT_W-1:0]       cnt_reg;
   logic                   pend_valid_reg;
   logic [IN_W-1:0]        pend_data_reg;
   logic                   done_reg;
   logic [6:0]             hex_reg [4];

   logic [BCD_W+BIN_W-1:0] shift_next;
   logic [6:0]             seg_w [4];
   logic [6:0]             hex3_next;

   assign shift_next = dd_step(bcd_reg, bin_reg);

   // One decoder per BCD nibble; nibble 3 is the tens digit
   for (genvar gi = 0; gi < 4; gi++) begin : g_seg
      seg7_decode u_seg (
         .digit (bcd_reg[gi*4 +: 4]),
         .seg   (seg_w[gi])
      );
   end

   // Leading-zero blanking applies to the tens digit only
   always_comb begin
      hex3_next = seg_w[3];
      if (BLANK_LEADING && (bcd_reg[15:12] == 4'd0))
         hex3_next = SEG_BLANK;
   end

   // Conversion FSM, pending capture and registered display outputs
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg      <= IDLE;
         bin_reg        <= '0;
         bcd_reg        <= '0;
         cnt_reg        <= '0;
         pend_valid_reg <= 1'b0;
         pend_data_reg  <= '0;
         done_reg       <= 1'b0;
         for (int n = 0; n < 4; n++)
            hex_reg[n] <= SEG_BLANK;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               // A fresh input beats a stale pending value
               if (in_valid || pend_valid_reg) begin
                  bin_reg        <= fx_to_bin(in_valid ? in_data : pend_data_reg,
                                              FRAC_ROUND);
                  bcd_reg        <= '0;
                  cnt_reg        <= '0;
                  pend_valid_reg <= 1'b0;
                  state_reg      <= SHIFT;
               end
            end
            SHIFT: begin
               bcd_reg <= shift_next[BCD_W+BIN_W-1:BIN_W];
               bin_reg <= shift_next[BIN_W-1:0];
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == CNT_W'(BIN_W - 1))
                  state_reg <= DONE;
               if (in_valid) begin
                  pend_valid_reg <= 1'b1;
                  pend_data_reg  <= in_data;
               end
            end
            DONE: begin
               hex_reg[3] <= hex3_next;
               hex_reg[2] <= seg_w[2];
               hex_reg[1] <= seg_w[1];
               hex_reg[0] <= seg_w[0];
               done_reg   <= 1'b1;
               state_reg  <= IDLE;
               if (in_valid) begin
                  pend_valid_reg <= 1'b1;
                  pend_data_reg  <= in_data;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy = (state_reg != IDLE);
   assign done = done_reg;
   assign HEX3 = hex_reg[3];
   assign HEX2 = hex_reg[2];
   assign HEX1 = hex_reg[1];
   assign HEX0 = hex_reg[0];

endmodule

// File: tb/tb_fx55_dec_display.sv
// Self-checking bench: two instances (round+blank, truncate+no-blank) driven
// by the same stimulus, compared against an edge-counting timing model and
// an arithmetic decimal formatter.
module tb_fx55_dec_display;

   logic             CLOCK_50 = 1'b0;
   logic             RESET_N;
   logic [9:0]       in_data;
   logic             in_valid;
   logic             busy0, done0, busy1, done1;
   logic [3:0][6:0]  hx0, hx1;

   always #5 CLOCK_50 = ~CLOCK_50;

   fx55_dec_display #(.FRAC_ROUND(1'b1), .BLANK_LEADING(1'b1)) u_dut0 (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .in_data  (in_data),
      .in_valid (in_valid),
      .busy     (busy0),
      .done     (done0),
      .HEX3     (hx0[3]),
      .HEX2     (hx0[2]),
      .HEX1     (hx0[1]),
      .HEX0     (hx0[0])
   );

   fx55_dec_display #(.FRAC_ROUND(1'b0), .BLANK_LEADING(1'b0)) u_dut1 (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .in_data  (in_data),
      .in_valid (in_valid),
      .busy     (busy1),
      .done     (done1),
      .HEX3     (hx1[3]),
      .HEX2     (hx1[2]),
      .HEX1     (hx1[1]),
      .HEX0     (hx1[0])
   );

   int checks   = 0;
   int failures = 0;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

   // Timing model state, in units of rising edges
   int              cyc;
   int              next_free;
   int              last_acc;
   bit              have_acc;
   int              done_edge;
   logic [9:0]      done_val;
   bit              pend_v;
   logic [9:0]      pend_d;
   logic [3:0][6:0] exp_hex0, exp_hex1;
   bit              exp_done;
   bit              exp_busy;
   int              done_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // Decimal rendering straight from the arithmetic definition
   function automatic logic [3:0][6:0] model_hex(input logic [9:0] v, input bit rnd,
                                                 input bit blank);
      int ip, fp, f, val, t, u, te, h;
      logic [3:0][6:0] r;
      ip  = int'(v) / 32;
      fp  = int'(v) % 32;
      f   = (fp * 100 + (rnd ? 16 : 0)) / 32;
      val = ip * 100 + f;
      t   = val / 1000;
      u   = (val / 100) % 10;
      te  = (val / 10) % 10;
      h   = val % 10;
      r[3] = (blank && t == 0) ? 7'b1111111 : seg_tab[t];
      r[2] = seg_tab[u];
      r[1] = seg_tab[te];
      r[0] = seg_tab[h];
      return r;
   endfunction

   task automatic model_edge(input bit v, input logic [9:0] d);
      cyc++;
      exp_done = 1'b0;
      if (cyc == done_edge) begin
         exp_hex0 = model_hex(done_val, 1'b1, 1'b1);
         exp_hex1 = model_hex(done_val, 1'b0, 1'b0);
         exp_done = 1'b1;
      end
      if (cyc >= next_free) begin
         if (v || pend_v) begin
            done_val  = v ? d : pend_d;
            pend_v    = 1'b0;
            have_acc  = 1'b1;
            last_acc  = cyc;
            next_free = cyc + 14;
            done_edge = cyc + 13;
         end
      end else if (v) begin
         pend_v = 1'b1;
         pend_d = d;
      end
      exp_busy = have_acc && (cyc >= last_acc) && (cyc <= last_acc + 12);
   endtask

   task automatic check_outputs();
      check("busy_a", 32'(busy0), 32'(exp_busy));
      check("busy_b", 32'(busy1), 32'(exp_busy));
      check("done_a", 32'(done0), 32'(exp_done));
      check("done_b", 32'(done1), 32'(exp_done));
      check("hex_a", 32'(hx0), 32'(exp_hex0));
      check("hex_b", 32'(hx1), 32'(exp_hex1));
      if (done0) begin
         done_seen++;
         $display("done cyc=%0d value=%h hex_a=%h hex_b=%h", cyc, done_val, hx0, hx1);
      end
   endtask

   task automatic step(input bit v, input logic [9:0] d);
      in_valid = v;
      in_data  = d;
      @(posedge CLOCK_50);
      model_edge(v, d);
      #1;
      check_outputs();
   endtask

   task automatic apply_reset();
      @(negedge CLOCK_50);
      in_valid  = 1'b0;
      RESET_N   = 1'b0;
      pend_v    = 1'b0;
      have_acc  = 1'b0;
      done_edge = -1;
      next_free = 0;
      exp_done  = 1'b0;
      exp_busy  = 1'b0;
      exp_hex0  = {4{7'b1111111}};
      exp_hex1  = {4{7'b1111111}};
      #1;
      check_outputs();
      repeat (2) begin
         @(posedge CLOCK_50);
         cyc++;
         #1;
         check_outputs();
      end
      @(negedge CLOCK_50);
      RESET_N = 1'b1;
   endtask

   initial begin
      RESET_N   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      cyc       = 0;
      done_seen = 0;
      pend_d    = '0;
      done_val  = '0;
      last_acc  = 0;
      apply_reset();

      // Single conversions of the documented values
      step(1'b1, 10'h020);
      repeat (15) step(1'b0, 10'h000);
      check("one_a", 32'(hx0), {4'b0, 7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000});
      step(1'b1, 10'h057);
      repeat (15) step(1'b0, 10'h000);
      check("e_round", 32'(hx0[0]), 32'(7'b0100100));
      check("e_trunc", 32'(hx1[0]), 32'(7'b1111001));
      step(1'b1, 10'h3FF);
      repeat (15) step(1'b0, 10'h000);
      check("max_a", 32'(hx0), {4'b0, 7'b0110000, 7'b1111001, 7'b0010000, 7'b1111000});
      step(1'b1, 10'h000);
      repeat (15) step(1'b0, 10'h000);
      check("zero_b3", 32'(hx1[3]), 32'(7'b1000000));

      // Pending register: newest busy-time value wins, middle one is lost
      done_seen = 0;
      step(1'b1, 10'h020);
      step(1'b0, 10'h000);
      step(1'b0, 10'h000);
      step(1'b1, 10'h040);
      step(1'b0, 10'h000);
      step(1'b1, 10'h060);
      repeat (30) step(1'b0, 10'h000);
      check("pend_dones", 32'(done_seen), 32'd2);
      check("pend_disp", 32'(hx0[2]), 32'(7'b0110000));

      // Reset mid-conversion, with a value parked in pending
      step(1'b1, 10'h0A5);
      step(1'b0, 10'h000);
      step(1'b1, 10'h111);
      repeat (3) step(1'b0, 10'h000);
      apply_reset();
      done_seen = 0;
      repeat (20) step(1'b0, 10'h000);
      check("rst_nodone", 32'(done_seen), 32'd0);
      step(1'b1, 10'h155);
      repeat (15) step(1'b0, 10'h000);

      // Held valid: periodic conversions every 14 cycles
      done_seen = 0;
      repeat (70) step(1'b1, 10'h040);
      check("held_dones", 32'(done_seen), 32'd5);
      repeat (15) step(1'b0, 10'h000);

      // Randomized traffic with varying valid density
      for (int blk = 0; blk < 30; blk++) begin
         int pct;
         pct = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 30 : 90);
         for (int k = 0; k < 100; k++)
            step($urandom_range(99) < pct, 10'($urandom));
         if (blk == 17)
            apply_reset();
      end
      repeat (30) step(1'b0, 10'h000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
